// File: rtl/dfa_stream_ctx_mgr.sv
// Per-stream context manager between the packet-inspection front end and one DFA engine.
// Saves/restores DFA state per stream, tracks a sticky match flag and match counters.
module dfa_stream_ctx_mgr #(
    parameter int STATE_W  = 11,
    parameter int STREAM_W = 6,
    parameter int COUNT_W  = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_state,
    input  logic                new_stream_id,
    input  logic [STREAM_W-1:0] stream_id,
    input  logic                enable,
    input  logic                eop,
    input  logic [7:0]          char_in,
    input  logic                char_in_vld,
    output logic [7:0]          dfa_char,
    output logic                dfa_char_vld,
    output logic [STATE_W-1:0]  dfa_state_in,
    output logic                dfa_state_in_vld,
    input  logic [STATE_W-1:0]  dfa_state_out,
    input  logic                dfa_accept,
    output logic                fired,
    output logic [COUNT_W-1:0]  stream_count,
    output logic [COUNT_W-1:0]  total_count
);

    localparam int NUM_STREAMS = 2**STREAM_W;

    logic [STATE_W-1:0]     ctx_mem   [NUM_STREAMS];
    logic [COUNT_W-1:0]     count_mem [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] stream_vld;

    logic [STATE_W-1:0]  state_r;
    logic                accept_r;
    logic [STREAM_W-1:0] cur_sid;
    logic [STATE_W-1:0]  restore_state_r;
    logic                restore_pend_r;

    logic                commit;
    logic                fired_clr;
    logic [STREAM_W-1:0] next_sid;
    logic [STATE_W-1:0]  restore_sel;
    logic [COUNT_W-1:0]  cur_count_rd;
    logic [COUNT_W-1:0]  cur_count_wr;
    logic [COUNT_W-1:0]  stream_count_nxt;

    function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] value);
        if (SATURATE && (&value)) begin
            return value;
        end
        return value + COUNT_W'(1);
    endfunction

    // NOTE: every signal assigned in an always_comb gets a value on every path, so no latches.
    always_comb begin
        commit       = eop && enable;
        fired_clr    = load_state || (eop && !enable);
        next_sid     = load_state ? stream_id : cur_sid;
        cur_count_rd = stream_vld[cur_sid] ? count_mem[cur_sid] : '0;
        cur_count_wr = fired ? count_inc(cur_count_rd) : cur_count_rd;
    end

    // Restore priority: fresh/unknown stream, then same-cycle commit bypass, then stored state.
    always_comb begin
        restore_sel = ctx_mem[stream_id];
        if (new_stream_id || !stream_vld[stream_id]) begin
            restore_sel = '0;
        end else if (commit && (cur_sid == stream_id)) begin
            restore_sel = state_r;
        end
    end

    always_comb begin
        stream_count_nxt = '0;
        if (commit && (next_sid == cur_sid)) begin
            stream_count_nxt = cur_count_wr;
        end else if (stream_vld[next_sid]) begin
            stream_count_nxt = count_mem[next_sid];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dfa_char     <= '0;
            dfa_char_vld <= 1'b0;
            state_r      <= '0;
            accept_r     <= 1'b0;
        end else begin
            dfa_char     <= char_in;
            dfa_char_vld <= char_in_vld;
            state_r      <= dfa_state_out;
            accept_r     <= dfa_accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restore_state_r  <= '0;
            restore_pend_r   <= 1'b0;
            dfa_state_in     <= '0;
            dfa_state_in_vld <= 1'b0;
        end else begin
            restore_pend_r   <= load_state;
            if (load_state) begin
                restore_state_r <= restore_sel;
            end
            dfa_state_in     <= restore_state_r;
            dfa_state_in_vld <= restore_pend_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sid      <= '0;
            stream_vld   <= '0;
            fired        <= 1'b0;
            stream_count <= '0;
            total_count  <= '0;
        end else begin
            cur_sid      <= next_sid;
            stream_count <= stream_count_nxt;
            if (commit) begin
                stream_vld[cur_sid] <= 1'b1;
            end
            if (accept_r) begin
                fired <= 1'b1;
            end else if (fired_clr) begin
                fired <= 1'b0;
            end
            if (commit && fired) begin
                total_count <= count_inc(total_count);
            end
        end
    end

    // NOTE: the context memories are intentionally not reset; stream_vld masks stale entries,
    // which keeps them mappable onto distributed RAM.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            ctx_mem[cur_sid]   <= state_r;
            count_mem[cur_sid] <= cur_count_wr;
        end
    end

endmodule

// File: tb/tb_dfa_stream_ctx_mgr.sv
// Self-checking bench for dfa_stream_ctx_mgr: directed scenarios plus random traffic
// compared against a per-stream array model, on three counter configurations at once.
module tb_dfa_stream_ctx_mgr;

    localparam int STATE_W  = 11;
    localparam int STREAM_W = 6;
    localparam int NS       = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                load_state = 1'b0;
    logic                new_stream_id = 1'b0;
    logic [STREAM_W-1:0] stream_id = '0;
    logic                enable = 1'b0;
    logic                eop = 1'b0;
    logic [7:0]          char_in = '0;
    logic                char_in_vld = 1'b0;
    logic [STATE_W-1:0]  dfa_state_out = '0;
    logic                dfa_accept = 1'b0;

    logic [7:0]          dfa_char;
    logic                dfa_char_vld;
    logic [STATE_W-1:0]  dfa_state_in;
    logic                dfa_state_in_vld;
    logic                fired;
    logic [15:0]         stream_count;
    logic [15:0]         total_count;

    logic [7:0]          s_char, w_char;
    logic                s_char_vld, w_char_vld;
    logic [STATE_W-1:0]  s_state_in, w_state_in;
    logic                s_state_in_vld, w_state_in_vld;
    logic                s_fired, w_fired;
    logic [3:0]          s_stream_count, w_stream_count;
    logic [3:0]          s_total_count, w_total_count;

    always #5 clk = ~clk;

    dfa_stream_ctx_mgr #(.STATE_W(STATE_W), .STREAM_W(STREAM_W), .COUNT_W(16), .SATURATE(1'b1)) u_main (
        .clk(clk), .rst(rst), .load_state(load_state), .new_stream_id(new_stream_id),
        .stream_id(stream_id), .enable(enable), .eop(eop), .char_in(char_in),
        .char_in_vld(char_in_vld), .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld),
        .dfa_state_in(dfa_state_in), .dfa_state_in_vld(dfa_state_in_vld),
        .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept), .fired(fired),
        .stream_count(stream_count), .total_count(total_count)
    );

    dfa_stream_ctx_mgr #(.STATE_W(STATE_W), .STREAM_W(STREAM_W), .COUNT_W(4), .SATURATE(1'b1)) u_sat4 (
        .clk(clk), .rst(rst), .load_state(load_state), .new_stream_id(new_stream_id),
        .stream_id(stream_id), .enable(enable), .eop(eop), .char_in(char_in),
        .char_in_vld(char_in_vld), .dfa_char(s_char), .dfa_char_vld(s_char_vld),
        .dfa_state_in(s_state_in), .dfa_state_in_vld(s_state_in_vld),
        .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept), .fired(s_fired),
        .stream_count(s_stream_count), .total_count(s_total_count)
    );

    dfa_stream_ctx_mgr #(.STATE_W(STATE_W), .STREAM_W(STREAM_W), .COUNT_W(4), .SATURATE(1'b0)) u_wrap4 (
        .clk(clk), .rst(rst), .load_state(load_state), .new_stream_id(new_stream_id),
        .stream_id(stream_id), .enable(enable), .eop(eop), .char_in(char_in),
        .char_in_vld(char_in_vld), .dfa_char(w_char), .dfa_char_vld(w_char_vld),
        .dfa_state_in(w_state_in), .dfa_state_in_vld(w_state_in_vld),
        .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept), .fired(w_fired),
        .stream_count(w_stream_count), .total_count(w_total_count)
    );

    int total_cmp = 0;
    int bad_cmp   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cmp++;
        if (obs !== exp) begin
            bad_cmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model; configuration 0 = 16-bit saturating, 1 = 4-bit saturating, 2 = 4-bit wrapping.
    int cfg_w   [3] = '{16, 4, 4};
    bit cfg_sat [3] = '{1'b1, 1'b1, 1'b0};
    bit ref_valid [NS];
    int ref_ctx   [NS];
    int ref_cnt   [3][NS];
    int ref_tot   [3];
    int ref_cur;
    int ref_state_r;
    bit ref_accept_r;
    bit ref_fired;
    bit pipe_v [2];
    int pipe_s [2];
    int exp_char;
    bit exp_char_vld;

    function automatic int bump(input int v, input int k);
        int top;
        top = (1 << cfg_w[k]) - 1;
        if (cfg_sat[k] && v == top) return v;
        return (v + 1) & top;
    endfunction

    function automatic int exp_stream(input int k);
        return ref_valid[ref_cur] ? ref_cnt[k][ref_cur] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) ref_valid[i] = 1'b0;
        for (int k = 0; k < 3; k++) ref_tot[k] = 0;
        ref_cur = 0; ref_state_r = 0; ref_accept_r = 1'b0; ref_fired = 1'b0;
        pipe_v[0] = 1'b0; pipe_v[1] = 1'b0; pipe_s[0] = 0; pipe_s[1] = 0;
        exp_char = 0; exp_char_vld = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit ns, input int sid, input bit en, input bit ep,
                              input int ch, input bit chv, input int dso, input bit dacc);
        bit commit;
        int sel;
        int base;
        commit = ep && en;
        sel = 0;
        if (ld && !ns && ref_valid[sid]) sel = (commit && ref_cur == sid) ? ref_state_r : ref_ctx[sid];
        pipe_v[1] = pipe_v[0];
        pipe_s[1] = pipe_s[0];
        pipe_v[0] = ld;
        if (ld) pipe_s[0] = sel;
        if (commit) begin
            for (int k = 0; k < 3; k++) begin
                base = ref_valid[ref_cur] ? ref_cnt[k][ref_cur] : 0;
                if (ref_fired) begin
                    base = bump(base, k);
                    ref_tot[k] = bump(ref_tot[k], k);
                end
                ref_cnt[k][ref_cur] = base;
            end
            ref_ctx[ref_cur] = ref_state_r;
            ref_valid[ref_cur] = 1'b1;
        end
        if (ref_accept_r) ref_fired = 1'b1;
        else if (ld || (ep && !en)) ref_fired = 1'b0;
        if (ld) ref_cur = sid;
        ref_state_r = dso;
        ref_accept_r = dacc;
        exp_char = ch;
        exp_char_vld = chv;
    endtask

    task automatic compare_all();
        check("dfa_char", dfa_char, exp_char);
        check("dfa_char_vld", dfa_char_vld, exp_char_vld);
        check("state_in_vld", dfa_state_in_vld, pipe_v[1]);
        if (pipe_v[1]) check("state_in", dfa_state_in, pipe_s[1]);
        check("fired", fired, ref_fired);
        check("stream_count", stream_count, exp_stream(0));
        check("total_count", total_count, ref_tot[0]);
        check("sat4_stream", s_stream_count, exp_stream(1));
        check("sat4_total", s_total_count, ref_tot[1]);
        check("wrap4_stream", w_stream_count, exp_stream(2));
        check("wrap4_total", w_total_count, ref_tot[2]);
    endtask

    // Called just after a falling edge: drive one cycle of inputs, advance, compare.
    task automatic tick(input bit ld, input bit ns, input int sid, input bit en, input bit ep,
                        input int dso, input bit dacc);
        int ch;
        bit chv;
        ch  = $urandom_range(0, 255);
        chv = 1'($urandom_range(0, 1));
        load_state    = ld;
        new_stream_id = ns;
        stream_id     = STREAM_W'(sid);
        enable        = en;
        eop           = ep;
        char_in       = 8'(ch);
        char_in_vld   = chv;
        dfa_state_out = STATE_W'(dso);
        dfa_accept    = dacc;
        model_step(ld, ns, sid, en, ep, ch, chv, dso, dacc);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Asserts reset between clock edges, checks the immediate effect, releases on a falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_fired", fired, 0);
        check("rst_total", total_count, 0);
        check("rst_state_in_vld", dfa_state_in_vld, 0);
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Fresh stream restores state 0 with a single strobe two cycles after load.
        tick(1, 0, 5, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("t1_vld", dfa_state_in_vld, 1);
        check("t1_state", dfa_state_in, 0);
        check("t1_count", stream_count, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("t1_vld_drop", dfa_state_in_vld, 0);

        // Matching packet on stream 3 commits state 0x1A5 and one match.
        tick(1, 1, 3, 0, 0, 'h010, 0);
        tick(0, 0, 0, 0, 0, 'h1A5, 1);
        tick(0, 0, 0, 0, 0, 'h1A5, 0);
        check("t2_fired", fired, 1);
        tick(0, 0, 0, 1, 1, 'h1A5, 0);
        check("t2_total", total_count, 1);
        check("t2_stream", stream_count, 1);
        tick(1, 0, 3, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("t2_restore", dfa_state_in, 'h1A5);

        // Disabled eop: no commit, flag cleared.
        tick(0, 0, 0, 0, 0, 'h0AB, 1);
        tick(0, 0, 0, 0, 0, 'h0AB, 0);
        tick(0, 0, 0, 0, 1, 'h0AB, 0);
        check("t3_fired", fired, 0);
        check("t3_total", total_count, 1);
        tick(1, 0, 3, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("t3_restore", dfa_state_in, 'h1A5);

        // Same-cycle commit and reload of stream 7 takes the bypass.
        tick(1, 1, 7, 0, 0, 'h055, 0);
        tick(0, 0, 0, 1, 1, 'h2F0, 0);
        tick(1, 0, 7, 1, 1, 'h2F0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("t4_bypass_vld", dfa_state_in_vld, 1);
        check("t4_bypass", dfa_state_in, 'h2F0);

        // 17 matching packets on stream 1: saturate vs wrap.
        do_reset();
        for (int p = 0; p < 17; p++) begin
            tick(1, 0, 1, 0, 0, 'h3C3, 0);
            tick(0, 0, 0, 0, 0, 'h3C3, 1);
            tick(0, 0, 0, 0, 0, 'h3C3, 0);
            tick(0, 0, 0, 1, 1, 'h3C3, 0);
        end
        check("t5_main_stream", stream_count, 17);
        check("t5_main_total", total_count, 17);
        check("t5_sat_stream", s_stream_count, 15);
        check("t5_sat_total", s_total_count, 15);
        check("t5_wrap_stream", w_stream_count, 1);
        check("t5_wrap_total", w_total_count, 1);

        // Reset mid-packet after an accept abandons the packet and forgets all streams.
        tick(1, 0, 9, 0, 0, 'h111, 0);
        tick(0, 0, 0, 0, 0, 'h111, 1);
        tick(0, 0, 0, 0, 0, 'h111, 0);
        check("t6_fired_pre", fired, 1);
        do_reset();
        tick(1, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        check("t6_restore_vld", dfa_state_in_vld, 1);
        check("t6_restore", dfa_state_in, 0);

        // Random traffic over a small ID range so loads, commits and bypasses collide often.
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2047), $urandom_range(0, 3) == 0);
        end

        $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
        $finish;
    end

endmodule
